// File: rtl/spi_defs_pkg.sv
// Shared definitions for the SPI SRAM bridge.
//   state_e        : bridge FSM encoding
//   CMD_*_DEF      : default 23K256-class opcodes
//   req_t          : one latched memory_bus request
package spi_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_DONE
    } state_e;

    localparam logic [7:0] CMD_READ_DEF  = 8'h03;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        we;
    } req_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift engine: divider, spi_clk, bit counter, TX/RX shifters.
//   clk, reset : system clock, synchronous active-high reset
//   start      : one-cycle pulse, loads frame_in and begins shifting
//   frame_in   : full frame, MSB sent first
//   miso       : serial in, sampled as sclk rises
//   busy       : high while shifting; drops in the final cycle of the last bit
//   rx_word    : last 16 bits sampled (first sampled bit ends at [15])
//   sclk, mosi : SPI clock (idles low) and serial out
module spi_shift_engine #(
    parameter int DIVIDE     = 2,
    parameter int TOTAL_BITS = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [TOTAL_BITS-1:0] frame_in,
    input  logic                  miso,
    output logic                  busy,
    output logic [15:0]           rx_word,
    output logic                  sclk,
    output logic                  mosi
);
    localparam int DW = $clog2(DIVIDE) + 1;
    localparam int BW = $clog2(TOTAL_BITS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL_BITS - 1);

    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  sclk_q, sclk_d;
    logic                  busy_q, busy_d;
    logic [TOTAL_BITS-1:0] tx_q, tx_d;
    // Only the trailing data word is ever consumed, so RX keeps 16 bits.
    logic [15:0]           rx_q, rx_d;
    logic                  tick, end_tick;

    always_comb begin
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        tick     = busy_q && (div_q == DIV_LAST);
        end_tick = tick && sclk_q && (bit_q == BIT_LAST);
        if (start) begin
            tx_d   = frame_in;
            div_d  = '0;
            bit_d  = '0;
            sclk_d = 1'b0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (tick) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[14:0], miso};
                end else begin
                    // MOSI only advances on the falling edge.
                    sclk_d = 1'b0;
                    tx_d   = {tx_q[TOTAL_BITS-2:0], 1'b0};
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) busy_d = 1'b0;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            busy_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            sclk_q <= sclk_d;
            busy_q <= busy_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
        end
    end

    // Early drop lets the caller leave SHIFT on the same edge the last bit ends.
    assign busy    = busy_q && !end_tick;
    assign rx_word = rx_q;
    assign sclk    = sclk_q;
    assign mosi    = tx_q[TOTAL_BITS-1];

endmodule

// File: rtl/spi_sram_bridge.sv
// Bridge from memory_bus to an external SPI SRAM (one 16-bit word per request).
//   clk, reset              : system clock, synchronous active-high reset
//   address, data_in        : word address / write data, latched on accept
//   bus_enable, write_enable: request strobe and direction, sampled while ready=1
//   data_out                : last word read, held until the next read completes
//   ready, done             : idle/accepting flag, one-cycle completion pulse
//   spi_cs/clk/mosi/miso    : SPI mode-0 pins to the SRAM
module spi_sram_bridge
    import spi_defs::*;
#(
    parameter int          DIVIDE       = 2,
    parameter int          ADDRESS_BITS = 16,
    parameter logic [7:0]  CMD_READ     = CMD_READ_DEF,
    parameter logic [7:0]  CMD_WRITE    = CMD_WRITE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        bus_enable,
    input  logic        write_enable,
    output logic        ready,
    output logic        done,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int TOTAL_BITS = 24 + ADDRESS_BITS;
    localparam int DW = $clog2(DIVIDE) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDE - 1);

    state_e                state_q, state_d;
    logic [DW-1:0]         cnt_q, cnt_d;
    req_t                  req_q, req_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  cs_q, cs_d;
    logic [15:0]           data_out_q, data_out_d;
    logic                  eng_start, eng_busy, eng_sclk, eng_mosi;
    logic [15:0]           eng_rx;
    logic [ADDRESS_BITS-1:0] byte_addr;
    logic [TOTAL_BITS-1:0]   frame;

    // Word address -> byte address; high byte lives at the even address.
    assign byte_addr = ADDRESS_BITS'({req_q.addr, 1'b0});
    // Reads clock out zeros during the data phase.
    assign frame = {req_q.we ? CMD_WRITE : CMD_READ, byte_addr,
                    req_q.we ? req_q.data : 16'h0000};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        cs_d       = cs_q;
        data_out_d = data_out_q;
        eng_start  = 1'b0;
        case (state_q)
            // DONE already has ready=1, so a new request can start here.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus_enable) begin
                    req_d   = '{addr: address, data: data_in, we: write_enable};
                    state_d = ST_CS_SETUP;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    cs_d    = 1'b0;
                end
            end
            ST_CS_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    eng_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!eng_busy) state_d = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    if (!req_q.we) data_out_d = eng_rx;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            cs_q       <= 1'b1;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            cs_q       <= cs_d;
            data_out_q <= data_out_d;
        end
    end

    spi_shift_engine #(
        .DIVIDE     (DIVIDE),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_engine (
        .clk      (clk),
        .reset    (reset),
        .start    (eng_start),
        .frame_in (frame),
        .miso     (spi_miso),
        .busy     (eng_busy),
        .rx_word  (eng_rx),
        .sclk     (eng_sclk),
        .mosi     (eng_mosi)
    );

    // First frame bit is presented during CS setup, before the engine is loaded.
    assign spi_mosi = (state_q == ST_CS_SETUP) ? frame[TOTAL_BITS-1] :
                      (state_q == ST_SHIFT)    ? eng_mosi : 1'b0;
    assign spi_clk  = eng_sclk;
    assign spi_cs   = cs_q;
    assign ready    = ready_q;
    assign done     = done_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Bench for spi_sram_bridge: DIVIDE=2 instance (a) and DIVIDE=1 instance (b),
// each talking to a behavioural 23K256-style SPI SRAM.
module tb_spi_sram_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, be_a, we_a, rdy_a, done_a, cs_a, sclk_a, mosi_a;
    logic        rst_b, be_b, we_b, rdy_b, done_b, cs_b, sclk_b, mosi_b;
    logic [15:0] addr_a, din_a, dout_a, addr_b, din_b, dout_b;
    wire         miso_a, miso_b;

    int total = 0;
    int bad   = 0;
    int busy_a = 0, busy_b = 0, dn_a = 0, dn_b = 0;

    spi_sram_bridge #(.DIVIDE(2)) dut_a (
        .clk(clk), .reset(rst_a), .address(addr_a), .data_in(din_a), .data_out(dout_a),
        .bus_enable(be_a), .write_enable(we_a), .ready(rdy_a), .done(done_a),
        .spi_cs(cs_a), .spi_clk(sclk_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
    );

    spi_sram_bridge #(.DIVIDE(1)) dut_b (
        .clk(clk), .reset(rst_b), .address(addr_b), .data_in(din_b), .data_out(dout_b),
        .bus_enable(be_b), .write_enable(we_b), .ready(rdy_b), .done(done_b),
        .spi_cs(cs_b), .spi_clk(sclk_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
    );

    always @(negedge clk) begin
        if (!rdy_a)  busy_a++;
        if (!rdy_b)  busy_b++;
        if (done_a)  dn_a++;
        if (done_b)  dn_b++;
    end

    // SPI SRAM model: sequential mode, 16-bit byte address.
    for (genvar k = 0; k < 2; k++) begin : mdl
        wire cs_w   = (k == 0) ? cs_a   : cs_b;
        wire sclk_w = (k == 0) ? sclk_a : sclk_b;
        wire mosi_w = (k == 0) ? mosi_a : mosi_b;
        logic [7:0]  mem [0:65535];
        logic [39:0] sr = '0;
        logic [39:0] last_frame = '0;
        int          cnt = 0;
        int          last_cnt = 0;
        logic [7:0]  cmd = '0;
        logic [15:0] base = '0;
        logic        miso_r = 1'b0;
        logic [7:0]  cur;
        int          idx;

        if (k == 0) begin : g0
            assign miso_a = miso_r;
        end else begin : g1
            assign miso_b = miso_r;
        end

        always @(posedge sclk_w or posedge cs_w) begin
            if (cs_w) begin
                last_frame = sr;
                last_cnt   = cnt;
                cnt        = 0;
                sr         = '0;
            end else begin
                sr = {sr[38:0], mosi_w};
                cnt++;
                if (cnt == 8)  cmd  = sr[7:0];
                if (cnt == 24) base = sr[15:0];
                if (cnt > 24 && (cnt % 8) == 0 && cmd == 8'h02)
                    mem[base + 16'((cnt - 32) / 8)] = sr[7:0];
            end
        end

        always @(negedge sclk_w) begin
            if (!cs_w && cmd == 8'h03 && cnt >= 24 && cnt < 40) begin
                idx    = cnt - 24;
                cur    = mem[base + 16'(idx / 8)];
                miso_r = cur[7 - (idx % 8)];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One request on instance a; returns at the negedge of the done cycle.
    // With inject set, a second request is strobed mid-frame and must be ignored.
    task automatic req_a(input logic we, input logic [15:0] addr, input logic [15:0] data,
                         input bit inject, output int busy, output logic [15:0] dout);
        int b0;
        bit seen;
        b0 = busy_a;
        seen = 1'b0;
        @(negedge clk);
        be_a = 1'b1; we_a = we; addr_a = addr; din_a = data;
        @(negedge clk);
        be_a = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (inject && n == 20) begin
                be_a = 1'b1; we_a = 1'b1; addr_a = 16'h0100; din_a = 16'hBEEF;
            end
            if (inject && n == 30) be_a = 1'b0;
            if (done_a) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen_a", seen, 1'b1);
        busy = busy_a - b0;
        dout = dout_a;
    endtask

    int          bz, d0, b0;
    logic [15:0] dv;
    bit          hit;
    logic        wv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] av [4] = '{16'h0003, 16'h0003, 16'h0004, 16'h0004};
    logic [15:0] dtv[4] = '{16'hA5A5, 16'h0000, 16'h5A5A, 16'h0000};
    logic [15:0] ev [4] = '{16'h0000, 16'hA5A5, 16'hA5A5, 16'h5A5A};

    initial begin
        rst_a = 1'b1; be_a = 1'b0; we_a = 1'b0; addr_a = '0; din_a = '0;
        rst_b = 1'b1; be_b = 1'b0; we_b = 1'b0; addr_b = '0; din_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy_a, 1'b1);
        chk("rst_done", done_a, 1'b0);
        chk("rst_cs", cs_a, 1'b1);
        chk("rst_sclk", sclk_a, 1'b0);
        chk("rst_mosi", mosi_a, 1'b0);
        chk("rst_dout", dout_a, 16'h0000);
        rst_a = 1'b0; rst_b = 1'b0;

        // Write 0x1234 to word 0x0005.
        d0 = dn_a;
        req_a(1'b1, 16'h0005, 16'h1234, 1'b0, bz, dv);
        chk("wr_busy", bz, 164);
        chk("wr_frame", mdl[0].last_frame, 40'h02_000A_1234);
        chk("wr_clks", mdl[0].last_cnt, 40);
        repeat (2) @(negedge clk);
        chk("wr_done_cnt", dn_a - d0, 1);

        // Read it back with an ignored request strobed mid-frame.
        d0 = dn_a;
        req_a(1'b0, 16'h0005, 16'h0000, 1'b1, bz, dv);
        chk("rd_data", dv, 16'h1234);
        chk("rd_frame", mdl[0].last_frame, 40'h03_000A_0000);
        chk("rd_busy", bz, 164);
        repeat (2) @(negedge clk);
        chk("rd_done_cnt", dn_a - d0, 1);
        chk("rd_cs_idle", cs_a, 1'b1);

        // Re-issue the ignored request; data_out must survive the write.
        req_a(1'b1, 16'h0100, 16'hBEEF, 1'b0, bz, dv);
        chk("reissue_frame", mdl[0].last_frame, 40'h02_0200_BEEF);
        chk("dout_held", dv, 16'h1234);
        req_a(1'b0, 16'h0100, 16'h0000, 1'b0, bz, dv);
        chk("rd_0100", dv, 16'hBEEF);

        // Reset in the middle of a frame.
        @(negedge clk);
        be_a = 1'b1; we_a = 1'b0; addr_a = 16'h0005;
        @(negedge clk);
        be_a = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (mdl[0].cnt == 20) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("bit20_reached", hit, 1'b1);
        rst_a = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs", cs_a, 1'b1);
        chk("mid_rst_sclk", sclk_a, 1'b0);
        chk("mid_rst_ready", rdy_a, 1'b1);
        chk("mid_rst_done", done_a, 1'b0);
        chk("mid_rst_dout", dout_a, 16'h0000);
        rst_a = 1'b0;
        req_a(1'b0, 16'h0005, 16'h0000, 1'b0, bz, dv);
        chk("post_rst_rd", dv, 16'h1234);
        chk("post_rst_busy", bz, 164);

        // DIVIDE=1, bus_enable held high: back-to-back alternating write/read.
        @(negedge clk);
        b0 = busy_b;
        be_b = 1'b1; we_b = wv[0]; addr_b = av[0]; din_b = dtv[0];
        @(negedge clk);
        we_b = wv[1]; addr_b = av[1]; din_b = dtv[1];
        for (int i = 0; i < 4; i++) begin
            hit = 1'b0;
            for (int n = 0; n < 300; n++) begin
                if (done_b) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk($sformatf("b2b_done%0d", i), hit, 1'b1);
            chk($sformatf("b2b_busy%0d", i), busy_b - b0, 82);
            chk($sformatf("b2b_dout%0d", i), dout_b, ev[i]);
            chk($sformatf("b2b_cs_hi%0d", i), cs_b, 1'b1);
            if (i == 0) chk("b2b_frame0", mdl[1].last_frame, 40'h02_0006_A5A5);
            if (i == 3) chk("b2b_frame3", mdl[1].last_frame, 40'h03_0008_0000);
            b0 = busy_b;
            if (i < 3) begin
                @(negedge clk);
                chk($sformatf("b2b_accept%0d", i), rdy_b, 1'b0);
                chk($sformatf("b2b_cs_lo%0d", i), cs_b, 1'b0);
                if (i + 2 < 4) begin
                    we_b = wv[i+2]; addr_b = av[i+2]; din_b = dtv[i+2];
                end else begin
                    be_b = 1'b0;
                end
            end
        end
        repeat (3) @(negedge clk);
        chk("b2b_idle", rdy_b, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
